// File: rtl/rect_motion_ctl_if.sv
// Control/position bundle between the input stage and the rectangle motion controller.
interface rect_motion_ctl_if #(
  parameter int unsigned POS_W = 12
);
  logic             en;
  logic             btn_left;
  logic             btn_right;
  logic             btn_up;
  logic             btn_down;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic             moving;
  logic             at_floor;

  modport master (
    output en, btn_left, btn_right, btn_up, btn_down,
    input  xpos, ypos, moving, at_floor
  );

  modport slave (
    input  en, btn_left, btn_right, btn_up, btn_down,
    output xpos, ypos, moving, at_floor
  );
endinterface

// File: rtl/rect_motion_ctl.sv
// Tick-paced 2-axis rectangle position controller with saturating bounds and an
// optional jump/fall vertical axis (GRAVITY=1).
module rect_motion_ctl #(
  parameter int unsigned POS_W      = 12,
  parameter int unsigned TICK_DIV   = 4_000_000,
  parameter int unsigned STEP       = 1,
  parameter int unsigned X_MAX      = 1023,
  parameter int unsigned Y_MAX      = 767,
  parameter int unsigned X_INIT     = 0,
  parameter int unsigned Y_INIT     = 0,
  parameter int unsigned GRAVITY    = 0,
  parameter int unsigned JUMP_TICKS = 32
) (
  input logic              clk,
  input logic              rst,
  rect_motion_ctl_if.slave bus
);

  localparam int unsigned CntW  = $clog2(TICK_DIV);
  localparam int unsigned RiseW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(TICK_DIV - 1);
  localparam logic [POS_W:0]   StepW    = (POS_W + 1)'(STEP);
  localparam logic [POS_W:0]   XMaxW    = (POS_W + 1)'(X_MAX);
  localparam logic [POS_W:0]   YMaxW    = (POS_W + 1)'(Y_MAX);
  localparam logic [POS_W-1:0] YMax     = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] XRst     = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] YRst     = (GRAVITY != 0) ? POS_W'(Y_MAX) : POS_W'(Y_INIT);
  localparam logic [RiseW-1:0] RiseLast = RiseW'(JUMP_TICKS - 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StRise = 2'd1, StFall = 2'd2} state_e;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [RiseW-1:0] rise_q, rise_d;
  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             up_q;
  logic             moving_q, moving_d;
  logic             tick, up_edge;
  logic [POS_W-1:0] x_inc, x_dec, y_inc, y_dec;

  // Sums are formed one bit wider than the position so the bound compare cannot wrap.
  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v,
                                               input logic [POS_W:0]   lim);
    logic [POS_W:0] s;
    s = {1'b0, v} + StepW;
    return (s > lim) ? lim[POS_W-1:0] : s[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] sat_dec(input logic [POS_W-1:0] v);
    return ({1'b0, v} >= StepW) ? v - StepW[POS_W-1:0] : '0;
  endfunction

  always_comb begin
    tick    = bus.en && (cnt_q == CntLast);
    up_edge = bus.btn_up && !up_q;
    x_inc   = sat_inc(xpos_q, XMaxW);
    x_dec   = sat_dec(xpos_q);
    y_inc   = sat_inc(ypos_q, YMaxW);
    y_dec   = sat_dec(ypos_q);

    cnt_d    = cnt_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    state_d  = state_q;
    rise_d   = rise_q;
    moving_d = moving_q;

    if (bus.en) cnt_d = tick ? '0 : cnt_q + CntW'(1);

    // Jump requests only latch while idle, so presses mid-air are dropped.
    if (!bus.en)                                               pend_d = 1'b0;
    else if ((GRAVITY != 0) && up_edge && (state_q == StIdle)) pend_d = 1'b1;
    else if (tick)                                             pend_d = 1'b0;
    else                                                       pend_d = pend_q;

    if (tick) begin
      if (bus.btn_right && !bus.btn_left)      xpos_d = x_inc;
      else if (bus.btn_left && !bus.btn_right) xpos_d = x_dec;

      if (GRAVITY == 0) begin
        if (bus.btn_down && !bus.btn_up)      ypos_d = y_inc;
        else if (bus.btn_up && !bus.btn_down) ypos_d = y_dec;
        moving_d = (xpos_d != xpos_q) || (ypos_d != ypos_q);
      end else begin
        case (state_q)
          StIdle: begin
            if (pend_q) begin
              ypos_d  = y_dec;
              rise_d  = '0;
              state_d = (JUMP_TICKS == 1) ? StFall : StRise;
            end
          end
          StRise: begin
            ypos_d = y_dec;
            rise_d = rise_q + RiseW'(1);
            if ((rise_d == RiseLast) || (y_dec == '0)) state_d = StFall;
          end
          StFall: begin
            ypos_d = y_inc;
            if (y_inc == YMax) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
        moving_d = (state_d != StIdle) || (xpos_d != xpos_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      xpos_q   <= XRst;
      ypos_q   <= YRst;
      state_q  <= StIdle;
      rise_q   <= '0;
      pend_q   <= 1'b0;
      up_q     <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      state_q  <= state_d;
      rise_q   <= rise_d;
      pend_q   <= pend_d;
      up_q     <= bus.btn_up;
      moving_q <= moving_d;
    end
  end

  assign bus.xpos     = xpos_q;
  assign bus.ypos     = ypos_q;
  assign bus.moving   = moving_q;
  assign bus.at_floor = (ypos_q == YMax);

endmodule
